hbm_rd_arbiter: RTL and testbench
=================================

# hbm_rd_arbiter

Round-robin read-channel arbiter that shares one HBM AXI read port among `NUM_REQ` internal read requesters (weight/activation/instruction fetch engines). It sits between the accelerator fetch engines and one HBM pseudo-channel AXI slave port. It issues one burst at a time, stamps the requester index onto ARID, and routes R beats back to the granted requester until RLAST. Only the read channels (AR/R) pass through this block; the write channels bypass it.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8
- `ID_W`, 2: downstream ARID width; must satisfy 2^`ID_W` ≥ `NUM_REQ`
- `ADDR_W`, 32: address width
- `DATA_W`, 128: data width; power of two, 32..512

Ports:
- `S_AXI_ACLK`  in  1: the single clock
- `S_AXI_ARESET`  in  1: asynchronous, active-high reset
- `REQ_ARVALID`  in  `NUM_REQ`: per-requester address valid
- `REQ_ARREADY`  out  `NUM_REQ`: per-requester address accept
- `REQ_ARADDR`  in  `NUM_REQ*ADDR_W`: packed addresses; requester i occupies slice i
- `REQ_ARLEN`  in  `NUM_REQ*8`: packed burst lengths (beats−1)
- `REQ_RVALID`  out  `NUM_REQ`: per-requester data valid
- `REQ_RREADY`  in  `NUM_REQ`: per-requester data ready
- `REQ_RDATA`  out  `DATA_W`: broadcast read data
- `REQ_RLAST`  out  1: broadcast last beat
- `M_AXI_ARID`  out  `ID_W`; `M_AXI_ARADDR`  out  `ADDR_W`; `M_AXI_ARLEN`  out  8; `M_AXI_ARSIZE`  out  3; `M_AXI_ARBURST`  out  2; `M_AXI_ARVALID`  out  1; `M_AXI_ARREADY`  in  1: AR channel to the HBM slave
- `M_AXI_RID`  in  `ID_W`; `M_AXI_RDATA`  in  `DATA_W`; `M_AXI_RRESP`  in  2; `M_AXI_RLAST`  in  1; `M_AXI_RVALID`  in  1; `M_AXI_RREADY`  out  1: R channel from the HBM slave
- `arb_err`  out  1: sticky protocol error flag

## Operation
- FSM states:
  - IDLE:
    - If any `REQ_ARVALID` is set, pick the first set bit at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
    - Register the winner into `gnt` (one-hot) and `gnt_idx`, then go to ADDR.
  - ADDR:
    - `M_AXI_ARVALID` = `REQ_ARVALID[gnt_idx]`.
    - ADDR/LEN are muxed combinationally from slice `gnt_idx`.
    - `M_AXI_ARID` = `gnt_idx`.
    - `REQ_ARREADY[gnt_idx]` = `M_AXI_ARREADY`; all other bits are 0.
    - On handshake: latch `beat_cnt`=0 and `len_q`=ARLEN, then go to DATA.
    - If `REQ_ARVALID[gnt_idx]` drops without a handshake, return to IDLE and leave `rr_ptr` unchanged.
  - DATA:
    - `REQ_RVALID[gnt_idx]` = `M_AXI_RVALID`.
    - `M_AXI_RREADY` = `REQ_RREADY[gnt_idx]`.
    - `REQ_RDATA`/`REQ_RLAST` are passed through unregistered.
    - Each beat increments `beat_cnt`.
    - On a beat with `M_AXI_RLAST`: go to IDLE and set `rr_ptr` = (`gnt_idx`+1) mod `NUM_REQ`.
- Constant outputs:
  - `M_AXI_ARSIZE` = log2(`DATA_W`/8).
  - `M_AXI_ARBURST` = 2'b01 (INCR).
- There is only one outstanding burst, which matches the single-burst HBM slave model. No new AR is issued until the current RLAST has been accepted.
- Requesters that are not granted see ARREADY=0 and RVALID=0 at all times.
- `M_AXI_RRESP` is ignored.

## Timing
- Reset values (asserted asynchronously):
  - state=IDLE, `rr_ptr`=0, `gnt`=0, `arb_err`=0.
  - All READY/VALID outputs are 0; `M_AXI_ARID`/ADDR/LEN are 0.
- Arbitration latency: a request seen in IDLE at edge n drives `M_AXI_ARVALID` in cycle n+1. The best case is 1 cycle from ARVALID to ARVALID.
- Turnaround: the RLAST beat at edge n gives IDLE in cycle n+1. The next grant's ARVALID appears in n+2, so there is a 2-cycle bubble between bursts.
- Simultaneous requests in IDLE: round-robin order from `rr_ptr`, so no requester starves.
- A new request arriving during ADDR/DATA waits and is not dropped; its ARVALID must stay asserted per AXI.
- `M_AXI_RVALID` arriving while in IDLE or ADDR is ignored (RREADY=0).
- Reset mid-burst: the block aborts immediately, and the downstream slave must be reset together with it.

## Configuration
- `HBM_RD_ARB_CHECK_EN` defined:
  - On each DATA beat, compare `beat_cnt` against `len_q`.
  - `arb_err` is set and held until reset on any of: `M_AXI_RLAST` with `beat_cnt`≠`len_q`; a beat with `beat_cnt`==`len_q` and no RLAST; `M_AXI_RID`≠`gnt_idx` on any beat.
  - Each error also raises a `$error` in simulation.
- Not defined: `arb_err` is tied to 0 and `beat_cnt`/`len_q` are not synthesized. FSM behaviour is unchanged.

## Structure
- Package `hbm_arb_pkg`:
  - state enum `arb_state_e` {IDLE, ADDR, DATA};
  - constant `AXI_BURST_INCR`=2'b01;
  - function `clog2_min1`.
- Sub-module `rr_pick`: combinational round-robin picker, `NUM_REQ`-wide request vector plus pointer in, one-hot grant plus index out. It is instantiated once.

## Test plan
- Single requester 2 issues ARADDR=0x100, ARLEN=3 → `M_AXI_ARID`=2, ARVALID one cycle after the request, 4 beats routed only to `REQ_RVALID[2]`, RLAST on beat 4, `arb_err`=0.
- All 4 requesters assert from reset → grant order 0,1,2,3, each ARLEN=0, a 2-cycle bubble between bursts, then 0 again if still requesting.
- Requester 1 deasserts `REQ_RREADY` for 5 cycles mid-burst → `M_AXI_RREADY` low for those cycles and no beat lost. Data matches HBM memory preloaded with an address pattern.
- Slave throttles via `M_AXI_ARREADY` held low for 10 cycles → the requester's ARREADY stays low and its ADDR/LEN stay stable.
- With `HBM_RD_ARB_CHECK_EN`: slave returns RLAST on beat 2 of ARLEN=3 → `arb_err`=1 and stays 1 until `S_AXI_ARESET`.
- `S_AXI_ARESET` asserted in DATA during beat 1 → all outputs 0 immediately. After release, requester 0 is granted first.

Source files
------------

// File: rtl/hbm_arb_pkg.sv
// ---------------------------------------------------------------------------
// hbm_arb_pkg
// Shared definitions for the HBM read-channel arbiter:
//   arb_state_e    : arbiter FSM states (IDLE, ADDR, DATA)
//   AXI_BURST_INCR : AXI ARBURST encoding for incrementing bursts
//   clog2_min1     : ceil(log2(n)) clamped to at least 1 (index widths)
// ---------------------------------------------------------------------------
package hbm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   // Width of an index able to address n items; never returns 0 so that a
   // single-entry index still gets a real bit.
   function automatic int clog2_min1(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) begin
         w++;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Selects the first set bit of req at or
// after ptr, wrapping modulo NUM_REQ.
//   req  in  NUM_REQ : request vector
//   ptr  in  IDX_W   : highest-priority position this round
//   gnt  out NUM_REQ : one-hot grant (0 when no request)
//   idx  out IDX_W   : index of the granted bit
//   any  out 1       : at least one request present
// ---------------------------------------------------------------------------
module rr_pick
   import hbm_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   // Walk the candidates from farthest to nearest so the candidate closest
   // to ptr is the last one written and therefore wins.
   always_comb begin : p_pick
      logic [IDX_W-1:0] cand;
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
         if (req[cand]) begin
            gnt       = '0;
            gnt[cand] = 1'b1;
            idx       = cand;
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hbm_rd_arbiter.sv
// ---------------------------------------------------------------------------
// hbm_rd_arbiter
// Round-robin arbiter sharing one HBM AXI read port (AR/R only) among
// NUM_REQ fetch engines. One burst outstanding at a time; the requester
// index is stamped on ARID and R beats are routed to the granted requester
// until RLAST.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET (async, active high)
//   REQ_AR{VALID,READY,ADDR,LEN} : per-requester address channel (packed)
//   REQ_R{VALID,READY}           : per-requester data handshake
//   REQ_R{DATA,LAST}             : broadcast read data / last
//   M_AXI_AR*, M_AXI_R*          : HBM pseudo-channel read port
//   arb_err                      : sticky burst-length / RID error flag
//
// Build option: define HBM_RD_ARB_CHECK_EN to enable the beat-count and
// RID checker driving arb_err; otherwise arb_err is constant 0.
// ---------------------------------------------------------------------------
module hbm_rd_arbiter
   import hbm_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 128
) (
   input  logic                      S_AXI_ACLK,
   input  logic                      S_AXI_ARESET,
   input  logic [NUM_REQ-1:0]        REQ_ARVALID,
   output logic [NUM_REQ-1:0]        REQ_ARREADY,
   input  logic [NUM_REQ*ADDR_W-1:0] REQ_ARADDR,
   input  logic [NUM_REQ*8-1:0]      REQ_ARLEN,
   output logic [NUM_REQ-1:0]        REQ_RVALID,
   input  logic [NUM_REQ-1:0]        REQ_RREADY,
   output logic [DATA_W-1:0]         REQ_RDATA,
   output logic                      REQ_RLAST,
   output logic [ID_W-1:0]           M_AXI_ARID,
   output logic [ADDR_W-1:0]         M_AXI_ARADDR,
   output logic [7:0]                M_AXI_ARLEN,
   output logic [2:0]                M_AXI_ARSIZE,
   output logic [1:0]                M_AXI_ARBURST,
   output logic                      M_AXI_ARVALID,
   input  logic                      M_AXI_ARREADY,
   input  logic [ID_W-1:0]           M_AXI_RID,
   input  logic [DATA_W-1:0]         M_AXI_RDATA,
   input  logic [1:0]                M_AXI_RRESP,
   input  logic                      M_AXI_RLAST,
   input  logic                      M_AXI_RVALID,
   output logic                      M_AXI_RREADY,
   output logic                      arb_err
);

   localparam int         IDX_W   = clog2_min1(NUM_REQ);
   localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_W / 8));

   arb_state_e          state_reg, state_next;
   logic [NUM_REQ-1:0]  gnt_reg;
   logic [IDX_W-1:0]    gnt_idx_reg;
   logic [IDX_W-1:0]    rr_ptr_reg;
   logic [IDX_W-1:0]    rr_ptr_inc;
   logic [NUM_REQ-1:0]  pick_gnt;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_any;
   logic                sel_arvalid;
   logic                ar_hs;
   logic                r_beat;
   logic [ADDR_W-1:0]   addr_slice [NUM_REQ];
   logic [7:0]          len_slice  [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign addr_slice[gi] = REQ_ARADDR[gi*ADDR_W +: ADDR_W];
         assign len_slice[gi]  = REQ_ARLEN[gi*8 +: 8];
      end
   endgenerate

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req (REQ_ARVALID),
      .ptr (rr_ptr_reg),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign rr_ptr_inc = (gnt_idx_reg == IDX_W'(NUM_REQ - 1)) ? '0
                                                             : gnt_idx_reg + IDX_W'(1);

   // Data is broadcast; only the granted requester sees RVALID.
   assign REQ_RDATA     = M_AXI_RDATA;
   assign REQ_RLAST     = M_AXI_RLAST;
   assign M_AXI_ARSIZE  = AR_SIZE;
   assign M_AXI_ARBURST = AXI_BURST_INCR;

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      REQ_ARREADY   = '0;
      REQ_RVALID    = '0;
      M_AXI_ARVALID = 1'b0;
      M_AXI_ARID    = '0;
      M_AXI_ARADDR  = '0;
      M_AXI_ARLEN   = '0;
      M_AXI_RREADY  = 1'b0;
      sel_arvalid   = REQ_ARVALID[gnt_idx_reg];
      ar_hs         = 1'b0;
      r_beat        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (pick_any) begin
               state_next = ADDR;
            end
         end
         ADDR: begin
            M_AXI_ARVALID = sel_arvalid;
            M_AXI_ARID    = ID_W'(gnt_idx_reg);
            M_AXI_ARADDR  = addr_slice[gnt_idx_reg];
            M_AXI_ARLEN   = len_slice[gnt_idx_reg];
            REQ_ARREADY   = gnt_reg & {NUM_REQ{M_AXI_ARREADY}};
            ar_hs         = sel_arvalid & M_AXI_ARREADY;
            if (ar_hs) begin
               state_next = DATA;
            end else if (!sel_arvalid) begin
               // Requester withdrew: re-arbitrate without moving the pointer.
               state_next = IDLE;
            end
         end
         DATA: begin
            REQ_RVALID   = gnt_reg & {NUM_REQ{M_AXI_RVALID}};
            M_AXI_RREADY = REQ_RREADY[gnt_idx_reg];
            r_beat       = M_AXI_RVALID & REQ_RREADY[gnt_idx_reg];
            if (r_beat && M_AXI_RLAST) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         gnt_reg     <= '0;
         gnt_idx_reg <= '0;
         rr_ptr_reg  <= '0;
      end else begin
         if (state_reg == IDLE && pick_any) begin
            gnt_reg     <= pick_gnt;
            gnt_idx_reg <= pick_idx;
         end
         // Pointer only advances once a burst fully completes.
         if (r_beat && M_AXI_RLAST) begin
            rr_ptr_reg <= rr_ptr_inc;
         end
      end
   end

`ifdef HBM_RD_ARB_CHECK_EN
   logic [7:0] beat_cnt_reg;
   logic [7:0] len_q_reg;
   logic       arb_err_reg;
   logic       err_len;
   logic       err_id;
   logic       unused_sink;

   // RLAST must coincide exactly with the final counted beat.
   assign err_len     = r_beat & (M_AXI_RLAST != (beat_cnt_reg == len_q_reg));
   assign err_id      = r_beat & (M_AXI_RID != ID_W'(gnt_idx_reg));
   assign arb_err     = arb_err_reg;
   assign unused_sink = ^M_AXI_RRESP;

   always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
      if (S_AXI_ARESET) begin
         beat_cnt_reg <= '0;
         len_q_reg    <= '0;
         arb_err_reg  <= 1'b0;
      end else begin
         if (ar_hs) begin
            beat_cnt_reg <= '0;
            len_q_reg    <= M_AXI_ARLEN;
         end else if (r_beat) begin
            beat_cnt_reg <= beat_cnt_reg + 8'd1;
         end
         if (err_len || err_id) begin
            arb_err_reg <= 1'b1;
`ifndef SYNTHESIS
            $error("hbm_rd_arbiter: burst error (len=%0b id=%0b)", err_len, err_id);
`endif
         end
      end
   end
`else
   logic unused_sink;
   assign unused_sink = ^{M_AXI_RRESP, M_AXI_RID};
   assign arb_err     = 1'b0;
`endif

endmodule

// File: tb/tb_hbm_rd_arbiter.sv
module tb_hbm_rd_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 128;

   logic clk = 1'b0;
   logic rst;
   logic [NUM_REQ-1:0]        req_arvalid, req_arready, req_rvalid, req_rready;
   logic [NUM_REQ*ADDR_W-1:0] req_araddr;
   logic [NUM_REQ*8-1:0]      req_arlen;
   logic [DATA_W-1:0]         req_rdata, m_rdata;
   logic                      req_rlast;
   logic [ID_W-1:0]           m_arid, m_rid;
   logic [ADDR_W-1:0]         m_araddr;
   logic [7:0]                m_arlen;
   logic [2:0]                m_arsize;
   logic [1:0]                m_arburst, m_rresp;
   logic                      m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
   logic                      arb_err;

   always #5 clk = ~clk;

   hbm_rd_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
      .REQ_ARVALID(req_arvalid), .REQ_ARREADY(req_arready),
      .REQ_ARADDR(req_araddr), .REQ_ARLEN(req_arlen),
      .REQ_RVALID(req_rvalid), .REQ_RREADY(req_rready),
      .REQ_RDATA(req_rdata), .REQ_RLAST(req_rlast),
      .M_AXI_ARID(m_arid), .M_AXI_ARADDR(m_araddr), .M_AXI_ARLEN(m_arlen),
      .M_AXI_ARSIZE(m_arsize), .M_AXI_ARBURST(m_arburst),
      .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(m_arready),
      .M_AXI_RID(m_rid), .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp),
      .M_AXI_RLAST(m_rlast), .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(m_rready),
      .arb_err(arb_err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Requester side
   bit          pend   [NUM_REQ];
   bit          active [NUM_REQ];
   bit          rrdy   [NUM_REQ];
   logic [31:0] raddr  [NUM_REQ];
   logic [7:0]  rlen   [NUM_REQ];
   int          rbeat  [NUM_REQ];
   int          issued [NUM_REQ];
   int          done   [NUM_REQ];
   int          gen_pct = 0;
   logic [3:0]  gen_mask = 4'h0;
   int          hold_r = 0, hold_cnt = 0;
   // HBM slave (one burst at a time, memory = address pattern)
   bit          s_busy, s_rv, s_arready, s_early_last;
   logic [31:0] s_addr;
   logic [7:0]  s_len;
   logic [1:0]  s_id, s_rresp;
   int          s_beat;
   int          ar_throttle = 0;
   // Arbiter reference: phase 0 idle, 1 address offered, 2 data
   int          ph, ptr, cur_id;
   bit          exp_err;
   int          dut_order[$];
   // Values seen during the previous cycle (what the DUT sampled at the edge)
   logic        p_m_arvalid, p_m_arready, p_m_rvalid, p_m_rready, p_m_rlast, p_req_rlast;
   logic [ID_W-1:0]    p_m_arid;
   logic [ADDR_W-1:0]  p_m_araddr;
   logic [7:0]         p_m_arlen;
   logic [NUM_REQ-1:0] p_req_arvalid, p_req_arready, p_req_rvalid, p_req_rready;

   function automatic logic [127:0] data_at(input logic [31:0] a);
      return {a ^ 32'hA5A5_0F0F, ~a, a + 32'h1234_5678, a};
   endfunction

   function automatic int rr_expect(input logic [NUM_REQ-1:0] v, input int p);
      for (int k = 0; k < NUM_REQ; k++) begin
         if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
      end
      return 0;
   endfunction

   task automatic drive();
      for (int r = 0; r < NUM_REQ; r++) begin
         req_arvalid[r]          = pend[r];
         req_araddr[r*32 +: 32]  = raddr[r];
         req_arlen[r*8 +: 8]     = rlen[r];
         req_rready[r]           = rrdy[r];
      end
      m_arready = s_arready;
      m_rvalid  = s_rv;
      m_rdata   = data_at(s_addr + 32'(s_beat * 16));
      m_rlast   = s_busy && ((s_beat == int'(s_len)) || (s_early_last && s_beat == 1));
      m_rid     = s_id;
      m_rresp   = s_rresp;
   endtask

   task automatic snapshot();
      p_m_arvalid = m_arvalid; p_m_arready = m_arready; p_m_arid = m_arid;
      p_m_araddr  = m_araddr;  p_m_arlen   = m_arlen;
      p_m_rvalid  = m_rvalid;  p_m_rready  = m_rready; p_m_rlast = m_rlast;
      p_req_arvalid = req_arvalid; p_req_arready = req_arready;
      p_req_rvalid  = req_rvalid;  p_req_rready  = req_rready; p_req_rlast = req_rlast;
   endtask

   task automatic inject(input int r, input logic [31:0] a, input logic [7:0] l);
      pend[r] = 1'b1; raddr[r] = a; rlen[r] = l; issued[r]++;
      drive();
      #1;
      snapshot();
   endtask

   task automatic check_cycle();
      logic [NUM_REQ-1:0] exp_rv;
      check_eq("arb_err", arb_err, exp_err);
      if (ph == 1) begin
         check_eq("arvalid", m_arvalid, 1'b1);
         check_eq("arid", m_arid, cur_id);
         check_eq("araddr", m_araddr, raddr[cur_id]);
         check_eq("arlen", m_arlen, rlen[cur_id]);
         check_eq("arsize", m_arsize, 3'd4);
         check_eq("arburst", m_arburst, 2'b01);
         check_eq("req_arready", req_arready, m_arready ? (4'b1 << cur_id) : 4'b0);
      end else begin
         check_eq("arvalid_off", m_arvalid, 1'b0);
         check_eq("req_arready_off", req_arready, 4'b0);
      end
      exp_rv = (ph == 2 && m_rvalid) ? (4'b1 << cur_id) : 4'b0;
      check_eq("req_rvalid", req_rvalid, exp_rv);
      check_eq("m_rready", m_rready, (ph == 2) ? rrdy[cur_id] : 1'b0);
      for (int r = 0; r < NUM_REQ; r++) begin
         if (req_rvalid[r] && req_rready[r]) begin
            check_eq("rdata", req_rdata, data_at(raddr[r] + 32'(rbeat[r] * 16)));
            if (!s_early_last) check_eq("rlast", req_rlast, rbeat[r] == int'(rlen[r]));
         end
      end
   endtask

   task automatic step();
      bit ar_hs, r_hs;
      @(posedge clk);
      #1;
      ar_hs = p_m_arvalid && p_m_arready;
      r_hs  = p_m_rvalid && p_m_rready;
      case (ph)
         0: if (p_req_arvalid != 0) begin cur_id = rr_expect(p_req_arvalid, ptr); ph = 1; end
         1: if (ar_hs) ph = 2;
         default: if (r_hs && p_m_rlast) begin ph = 0; ptr = (cur_id + 1) % NUM_REQ; end
      endcase
`ifdef HBM_RD_ARB_CHECK_EN
      if (r_hs && (p_m_rlast != (s_beat == int'(s_len)))) exp_err = 1'b1;
`endif
      if (ar_hs) dut_order.push_back(int'(p_m_arid));
      for (int r = 0; r < NUM_REQ; r++) begin
         if (p_req_arvalid[r] && p_req_arready[r]) begin
            pend[r] = 1'b0; active[r] = 1'b1; rbeat[r] = 0;
         end
         if (p_req_rvalid[r] && p_req_rready[r]) begin
            if (p_req_rlast) begin active[r] = 1'b0; done[r]++; end
            else rbeat[r]++;
         end
      end
      if (r_hs) begin
         if (p_m_rlast) s_busy = 1'b0; else s_beat++;
         s_rv = 1'b0;
      end
      if (ar_hs) begin
         s_busy = 1'b1; s_addr = p_m_araddr; s_len = p_m_arlen; s_id = p_m_arid;
         s_beat = 0; s_rv = 1'b0;
      end
      // New stimulus for this cycle
      for (int r = 0; r < NUM_REQ; r++) begin
         if (!pend[r] && !active[r] && gen_mask[r] && $urandom_range(0, 99) < gen_pct) begin
            pend[r] = 1'b1; raddr[r] = $urandom & 32'hFFFF_FFF0;
            rlen[r] = 8'($urandom_range(0, 7)); issued[r]++;
         end
         rrdy[r] = ($urandom_range(0, 3) != 0);
         if (hold_cnt > 0 && r == hold_r) rrdy[r] = 1'b0;
      end
      if (hold_cnt > 0) hold_cnt--;
      s_arready = !s_busy && (ar_throttle == 0) && ($urandom_range(0, 2) != 0);
      if (ar_throttle > 0) ar_throttle--;
      if (s_busy && !s_rv && $urandom_range(0, 2) != 0) s_rv = 1'b1;
      s_rresp = 2'($urandom);
      drive();
      #1;
      check_cycle();
      snapshot();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check_eq("rst_req_arready", req_arready, 4'b0);
      check_eq("rst_req_rvalid", req_rvalid, 4'b0);
      check_eq("rst_m_arvalid", m_arvalid, 1'b0);
      check_eq("rst_m_rready", m_rready, 1'b0);
      check_eq("rst_m_arid", m_arid, 2'b0);
      check_eq("rst_m_araddr", m_araddr, 32'b0);
      check_eq("rst_m_arlen", m_arlen, 8'b0);
      check_eq("rst_arb_err", arb_err, 1'b0);
      for (int r = 0; r < NUM_REQ; r++) begin
         pend[r] = 0; active[r] = 0; rrdy[r] = 0; rbeat[r] = 0;
         raddr[r] = '0; rlen[r] = '0; issued[r] = 0; done[r] = 0;
      end
      s_busy = 0; s_rv = 0; s_arready = 0; s_early_last = 0; s_addr = '0;
      s_len = '0; s_id = '0; s_rresp = '0; s_beat = 0;
      ph = 0; ptr = 0; cur_id = 0; exp_err = 0; hold_cnt = 0; ar_throttle = 0;
      dut_order.delete();
      drive();
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      snapshot();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      do_reset();

      // Single requester 2, ARADDR=0x100, ARLEN=3
      inject(2, 32'h100, 8'd3);
      run(40);
      check_eq("single_done", done[2], 1);
      check_eq("single_id", (dut_order.size() > 0) ? dut_order[0] : -1, 2);
      $display("txn single: req2 bursts=%0d", done[2]);

      // All four request together straight after reset
      do_reset();
      for (int r = 0; r < NUM_REQ; r++) inject(r, 32'h1000 * (r + 1), 8'd0);
      run(40);
      for (int i = 0; i < NUM_REQ; i++)
         check_eq("rr_order", (dut_order.size() > i) ? dut_order[i] : -1, i);
      $display("txn rr: %0d grants observed", dut_order.size());

      // Requester 1 stalls RREADY for 5 cycles mid-burst
      inject(1, 32'h2000, 8'd7);
      for (int i = 0; i < 60 && !(ph == 2 && rbeat[1] >= 2); i++) step();
      check_eq("reach_mid_burst", ph == 2 && rbeat[1] >= 2, 1'b1);
      hold_r = 1; hold_cnt = 5;
      run(50);
      check_eq("stall_done", done[1], 2);
      $display("txn stall: req1 bursts=%0d", done[1]);

      // Slave holds ARREADY low for 10 cycles
      ar_throttle = 10;
      inject(3, 32'h3000, 8'd2);
      run(40);
      check_eq("throttle_done", done[3], 2);
      $display("txn throttle: req3 bursts=%0d", done[3]);

      // Random traffic, then drain
      gen_mask = 4'hF; gen_pct = 20;
      run(1500);
      gen_mask = 4'h0;
      for (int i = 0; i < 400; i++) begin
         bit busy;
         busy = (ph != 0);
         for (int r = 0; r < NUM_REQ; r++) busy |= pend[r] | active[r];
         if (!busy) break;
         step();
      end
      for (int r = 0; r < NUM_REQ; r++) begin
         check_eq("drain", done[r], issued[r]);
         $display("txn random: req%0d issued=%0d done=%0d", r, issued[r], done[r]);
      end

`ifdef HBM_RD_ARB_CHECK_EN
      // Early RLAST on beat 2 of a 4-beat burst
      s_early_last = 1'b1;
      inject(0, 32'h4000, 8'd3);
      run(30);
      s_early_last = 1'b0;
      check_eq("err_set", arb_err, 1'b1);
      inject(1, 32'h5000, 8'd1);
      run(30);
      check_eq("err_sticky", arb_err, 1'b1);
      $display("txn err: arb_err=%0b", arb_err);
`endif

      // Reset while beat 1 is on the bus
      inject(2, 32'h8000, 8'd7);
      for (int i = 0; i < 60 && !(ph == 2 && m_rvalid); i++) step();
      check_eq("reach_beat1", ph == 2 && m_rvalid, 1'b1);
      do_reset();
      inject(3, 32'h9000, 8'd1);
      inject(0, 32'hA000, 8'd1);
      run(40);
      check_eq("post_rst_first", (dut_order.size() > 0) ? dut_order[0] : -1, 0);
      check_eq("post_rst_done", done[0] + done[3], 2);
      $display("txn midreset: first grant=%0d", (dut_order.size() > 0) ? dut_order[0] : -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
